// File: rtl/act_pkg.sv
// act_pkg: shared types and helpers for the activation/requantisation stage.
//   act_mode_t - per-beat activation selector (pass, relu, leaky, clip)
//   sat_max/sat_min - signed saturation bounds for a given width, returned
//                     sign-extended to SatMaxW bits so callers can truncate
//                     to whatever working width they need.
package act_pkg;

  typedef enum logic [1:0] {
    ActPass  = 2'd0,
    ActRelu  = 2'd1,
    ActLeaky = 2'd2,
    ActClip  = 2'd3
  } act_mode_t;

  localparam int unsigned SatMaxW = 128;

  // Largest value representable in a w-bit signed number.
  function automatic logic signed [SatMaxW-1:0] sat_max(input int unsigned w);
    logic signed [SatMaxW-1:0] one;
    one = SatMaxW'(1);
    return (one <<< (w - 1)) - one;
  endfunction

  // Smallest value representable in a w-bit signed number.
  function automatic logic signed [SatMaxW-1:0] sat_min(input int unsigned w);
    logic signed [SatMaxW-1:0] one;
    one = SatMaxW'(1);
    return -(one <<< (w - 1));
  endfunction

endpackage

// File: rtl/act_lane.sv
// act_lane: single-lane datapath of the activation unit.
//   S1: activation on the full-width accumulator (registered into act_q).
//   S2: rounded arithmetic right shift, OutW saturation, optional clip clamp
//       (registered into y_o / sat_o).
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   s1_en_i, s2_en_i   stage load enables from the top-level handshake
//   x_i                accumulator input (signed, InW)
//   mode_i, leak_sh_i  S1 config, taken with the incoming beat
//   s2_mode_i, q_sh_i, clip_i  S2 config, travelling with the beat in S1
//   y_o                saturated/clipped result (signed, OutW)
//   sat_o              1 when OutW saturation changed the value
module act_lane
  import act_pkg::*;
#(
  parameter int unsigned InW  = 64,
  parameter int unsigned OutW = 16,
  parameter int unsigned ShW  = 6
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   s1_en_i,
  input  logic                   s2_en_i,
  input  logic signed [InW-1:0]  x_i,
  input  act_mode_t              mode_i,
  input  logic [ShW-1:0]         leak_sh_i,
  input  act_mode_t              s2_mode_i,
  input  logic [ShW-1:0]         q_sh_i,
  input  logic signed [OutW-1:0] clip_i,
  output logic signed [OutW-1:0] y_o,
  output logic                   sat_o
);

  localparam logic signed [InW:0] ZMax = (InW + 1)'(sat_max(OutW));
  localparam logic signed [InW:0] ZMin = (InW + 1)'(sat_min(OutW));

  logic signed [InW-1:0]  act_d, act_q;
  logic signed [InW:0]    ext, rnd, z;
  logic signed [OutW-1:0] res_d, res_q;
  logic                   sat_d, sat_q;

  // S1: activation
  always_comb begin
    act_d = x_i;
    case (mode_i)
      ActRelu, ActClip: if (x_i <= 0) act_d = '0;
      ActLeaky:         if (x_i < 0) act_d = x_i >>> leak_sh_i;
      default:          act_d = x_i;
    endcase
  end

  // S2: requantise at InW+1 bits so the rounding add cannot overflow
  always_comb begin
    ext = {act_q[InW-1], act_q};
    rnd = '0;
    if (q_sh_i == '0) begin
      z = ext;
    end else if (32'(q_sh_i) >= InW) begin
      // Everything is shifted out; only the sign survives, rounding ignored.
      z = act_q[InW-1] ? '1 : '0;
    end else begin
      rnd = (InW + 1)'(1) <<< (q_sh_i - 1'b1);
      z   = (ext + rnd) >>> q_sh_i;
    end

    sat_d = 1'b0;
    if (z > ZMax) begin
      res_d = OutW'(ZMax);
      sat_d = 1'b1;
    end else if (z < ZMin) begin
      res_d = OutW'(ZMin);
      sat_d = 1'b1;
    end else begin
      res_d = z[OutW-1:0];
    end

    // Clip clamp is applied after saturation and never counts as a sat event.
    if (s2_mode_i == ActClip && res_d > clip_i) res_d = clip_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      act_q <= '0;
      res_q <= '0;
      sat_q <= 1'b0;
    end else begin
      if (s1_en_i) act_q <= act_d;
      if (s2_en_i) begin
        res_q <= res_d;
        sat_q <= sat_d;
      end
    end
  end

  assign y_o   = res_q;
  assign sat_o = sat_q;

endmodule

// File: rtl/activation_unit.sv
// activation_unit: pipelined multi-lane activation + requantisation stage.
// Two register stages (S1 activation, S2 round/saturate/clip), 1 beat/cycle,
// 2-cycle latency; all cfg_* are captured with each beat and travel with it.
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   cfg_mode/leak_sh/q_sh/clip       per-beat configuration
//   in_valid/in_ready/in_data/in_last     input stream (LANES x IN_W)
//   out_valid/out_ready/out_data/out_last output stream (LANES x OUT_W)
//   sat_count                        saturation event counter, present only
//                                    when ACT_SAT_CNT_EN is defined
module activation_unit
  import act_pkg::*;
#(
  parameter int unsigned IN_W  = 64,
  parameter int unsigned OUT_W = 16,
  parameter int unsigned LANES = 4,
  parameter int unsigned SH_W  = 6
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             cfg_mode,
  input  logic [SH_W-1:0]        cfg_leak_sh,
  input  logic [SH_W-1:0]        cfg_q_sh,
  input  logic [OUT_W-1:0]       cfg_clip,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*IN_W-1:0]  in_data,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*OUT_W-1:0] out_data,
  output logic                   out_last
`ifdef ACT_SAT_CNT_EN
  ,
  output logic [31:0]            sat_count
`endif
);

  logic             s1_valid_q, s2_valid_q;
  logic             s1_last_q, s2_last_q;
  act_mode_t        s1_mode_q;
  logic [SH_W-1:0]  s1_q_sh_q;
  logic [OUT_W-1:0] s1_clip_q;
  logic             s1_load, s2_load, in_fire;
  logic [LANES-1:0] sat_flags;

  // Ready path is combinational so a full pipe can still move every cycle.
  assign s2_load  = !s2_valid_q || out_ready;
  assign s1_load  = !s1_valid_q || s2_load;
  assign in_ready = s1_load;
  assign in_fire  = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s2_last_q  <= 1'b0;
      s1_mode_q  <= ActPass;
      s1_q_sh_q  <= '0;
      s1_clip_q  <= '0;
    end else begin
      if (s1_load) s1_valid_q <= in_valid;
      if (in_fire) begin
        s1_last_q <= in_last;
        s1_mode_q <= act_mode_t'(cfg_mode);
        s1_q_sh_q <= cfg_q_sh;
        s1_clip_q <= cfg_clip;
      end
      if (s2_load) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) s2_last_q <= s1_last_q;
      end
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    act_lane #(
      .InW (IN_W),
      .OutW(OUT_W),
      .ShW (SH_W)
    ) u_lane (
      .clk_i    (clk),
      .rst_ni   (rst_n),
      .s1_en_i  (in_fire),
      .s2_en_i  (s2_load && s1_valid_q),
      .x_i      (in_data[i*IN_W +: IN_W]),
      .mode_i   (act_mode_t'(cfg_mode)),
      .leak_sh_i(cfg_leak_sh),
      .s2_mode_i(s1_mode_q),
      .q_sh_i   (s1_q_sh_q),
      .clip_i   (s1_clip_q),
      .y_o      (out_data[i*OUT_W +: OUT_W]),
      .sat_o    (sat_flags[i])
    );
  end

  assign out_valid = s2_valid_q;
  assign out_last  = s2_last_q;

`ifdef ACT_SAT_CNT_EN
  logic [31:0] sat_cnt_q, sat_cnt_d;
  logic [32:0] sat_sum;

  // Counted when the beat leaves, so stalled beats are counted exactly once.
  always_comb begin
    sat_sum   = {1'b0, sat_cnt_q};
    sat_cnt_d = sat_cnt_q;
    if (out_valid && out_ready) begin
      for (int i = 0; i < LANES; i++) sat_sum = sat_sum + 33'(sat_flags[i]);
      sat_cnt_d = sat_sum[32] ? '1 : sat_sum[31:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sat_cnt_q <= '0;
    else        sat_cnt_q <= sat_cnt_d;
  end

  assign sat_count = sat_cnt_q;
`else
  logic unused_sat_flags;
  assign unused_sat_flags = ^sat_flags;
`endif

endmodule

// File: doc/activation_unit.md
# activation_unit

Parametrised, pipelined, multi-lane activation and requantisation stage for the conv datapath. It replaces the single-lane combinational ReLU. It accepts `LANES` signed accumulator values per beat over a valid/ready stream and applies one of four selectable activations. It then rescales with a rounded arithmetic shift and saturates each lane to `OUT_W` bits before handing off to the pooling/writeback stage.

## Interface
Parameters:
- `IN_W`, 64, accumulator width per lane (signed)
- `OUT_W`, 16, output width per lane (signed), `OUT_W` < `IN_W`
- `LANES`, 4, lanes per beat
- `SH_W`, 6, width of shift fields

Ports:
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `cfg_mode`  in  2  0=PASS, 1=RELU, 2=LEAKY, 3=CLIP
- `cfg_leak_sh`  in  SH_W  LEAKY negative-slope shift (slope = 2^-cfg_leak_sh)
- `cfg_q_sh`  in  SH_W  requantisation right shift
- `cfg_clip`  in  OUT_W  CLIP upper bound, non-negative
- `in_valid`  in  1  input beat valid
- `in_ready`  out  1  block can accept a beat
- `in_data`  in  LANES*IN_W  lane i at `[i*IN_W +: IN_W]`
- `in_last`  in  1  last beat of tile
- `out_valid`  out  1  output beat valid
- `out_ready`  in  1  downstream accepts
- `out_data`  out  LANES*OUT_W  lane i at `[i*OUT_W +: OUT_W]`
- `out_last`  out  1  `in_last` delayed with its beat
- `sat_count`  out  32  saturation event counter (only with `ACT_SAT_CNT_EN`)

## Operation
- A beat transfers on `in_valid && in_ready`. All `cfg_*` are captured with the beat and travel with it, so config may change between beats.
- Stage 1 (activation, full `IN_W`), per lane with x = input:
  - PASS: y = x
  - RELU: y = (x <= 0) ? 0 : x
  - LEAKY: y = (x < 0) ? (x >>> cfg_leak_sh) : x. The shift is arithmetic, so -1 stays -1.
  - CLIP: y = (x <= 0) ? 0 : x
- Stage 2 (requantise, per lane):
  - If `cfg_q_sh` = 0, then z = y. Otherwise z = (y + 2^(cfg_q_sh-1)) >>> cfg_q_sh, computed at `IN_W`+1 bits so the rounding add cannot overflow.
  - Saturate z to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - In CLIP mode, additionally apply min(result, cfg_clip).
  - A lane counts as a saturation event when the `OUT_W` saturation alters its value. The CLIP clamp is not a saturation event.
- `cfg_q_sh` ≥ `IN_W`: the result is 0 for y ≥ 0 and -1 for y < 0 (the rounding term is ignored).

## Timing
- Two register stages: S1 and S2. Latency is 2 cycles from accept to `out_valid` with no stall. Throughput is 1 beat/cycle.
- S2 loads when !S2.valid || out_ready. S1 loads when !S1.valid || S2 loads. `in_ready` = !S1.valid || S2 loads. The ready path is combinational; the data path is registered.
- While `out_valid && !out_ready`, `out_data` and `out_last` are held stable.
- Reset: `out_valid`=0, `out_data`=0, `out_last`=0, internal valids=0, `sat_count`=0. `in_ready` reads 1 during and after reset.
- Reset mid-stream drops all in-flight beats. No partial output is produced.
- Lane order, `in_last` alignment and beat order are preserved exactly.

## Configuration
- `ACT_SAT_CNT_EN` defined:
  - The `sat_count` port exists.
  - It increments by the number of saturated lanes in each beat accepted downstream (`out_valid && out_ready`).
  - It saturates at 2^32-1 and is cleared only by reset.
- Not defined: no port, no counter logic. Data behaviour is identical.

## Structure
- Package `act_pkg`: mode enum `act_mode_t` (PASS, RELU, LEAKY, CLIP) and saturation min/max helper functions parameterised on width.
- Sub-module `act_lane`: one lane's S1 activation and S2 round/saturate/clip datapath, plus a `sat` flag. It is instantiated `LANES` times via generate. Handshake control and the counter stay in the top level.

## Test plan
- RELU, `cfg_q_sh`=0, lanes {-5, 0, 7, 32767}, `out_ready`=1 -> {0, 0, 7, 32767} two cycles after accept; no saturation events.
- LEAKY, `cfg_leak_sh`=3, `cfg_q_sh`=0, lanes {-80, -1, 16, -8} -> {-10, -1, 16, -1}.
- PASS, `cfg_q_sh`=4, lanes {24, -24, 40000*16, -40000*16} -> {2, -1, 32767, -32768}; with the macro, `sat_count` goes 0 -> 2.
- CLIP, `cfg_clip`=6, `cfg_q_sh`=2, lanes {100, 20, -3, 26} -> {6, 5, 0, 6}; `sat_count` unchanged.
- Backpressure: stream 8 beats with `out_ready` toggling 1,0,0,1 and config switched on beat 4 -> all 8 beats out in order, each uses its own config, data stable while stalled, `out_last` on beat 8 only; never more than 2 beats in flight.
- Assert `rst_n`=0 with 2 beats in flight -> `out_valid`=0 immediately; first beat after release is the first one accepted post-reset.
